// File: rtl/idex_if.sv
// ID/EX register bus: decode-side inputs and execute-side outputs.
// The hazard controls travel with the bus they act on.
interface idex_if #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 3,
    parameter int CNT_W      = 8
);
    logic                  Stall_IDEX;
    logic                  Flush_IDEX;
    logic                  Valid_IFID;
    logic [DATA_W-1:0]     PCPlus1_IFID;
    logic [DATA_W-1:0]     ReadData1_ID;
    logic [DATA_W-1:0]     ReadData2_ID;
    logic [DATA_W-1:0]     Imm_ID;
    logic [REG_ADDR_W-1:0] Rs_ID;
    logic [REG_ADDR_W-1:0] Rt_ID;
    logic [REG_ADDR_W-1:0] Rd_ID;
    logic                  RegWrite_ID;
    logic                  MemRead_ID;
    logic                  MemWrite_ID;
    logic                  Link_ID;
    logic                  Slt_ID;
    logic                  Sgt_ID;
    logic [ALUOP_W-1:0]    ALUOp_ID;

    logic [DATA_W-1:0]     PCPlus1_IDEX;
    logic [DATA_W-1:0]     ReadData1_IDEX;
    logic [DATA_W-1:0]     ReadData2_IDEX;
    logic [DATA_W-1:0]     Imm_IDEX;
    logic [REG_ADDR_W-1:0] Rs_IDEX;
    logic [REG_ADDR_W-1:0] Rt_IDEX;
    logic [REG_ADDR_W-1:0] Rd_IDEX;
    logic                  RegWrite_IDEX;
    logic                  MemRead_IDEX;
    logic                  MemWrite_IDEX;
    logic                  Link_IDEX;
    logic                  Slt_IDEX;
    logic                  Sgt_IDEX;
    logic [ALUOP_W-1:0]    ALUOp_IDEX;
    logic                  lessthan_IDEX;
    logic                  greaterthan_IDEX;
    logic                  Valid_IDEX;
    logic                  SelConflict_IDEX;
    logic [CNT_W-1:0]      BubbleCount;

    modport master (
        output Stall_IDEX, Flush_IDEX, Valid_IFID, PCPlus1_IFID,
        output ReadData1_ID, ReadData2_ID, Imm_ID, Rs_ID, Rt_ID, Rd_ID,
        output RegWrite_ID, MemRead_ID, MemWrite_ID,
        output Link_ID, Slt_ID, Sgt_ID, ALUOp_ID,
        input  PCPlus1_IDEX, ReadData1_IDEX, ReadData2_IDEX, Imm_IDEX,
        input  Rs_IDEX, Rt_IDEX, Rd_IDEX,
        input  RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
        input  Link_IDEX, Slt_IDEX, Sgt_IDEX, ALUOp_IDEX,
        input  lessthan_IDEX, greaterthan_IDEX, Valid_IDEX,
        input  SelConflict_IDEX, BubbleCount
    );

    modport slave (
        input  Stall_IDEX, Flush_IDEX, Valid_IFID, PCPlus1_IFID,
        input  ReadData1_ID, ReadData2_ID, Imm_ID, Rs_ID, Rt_ID, Rd_ID,
        input  RegWrite_ID, MemRead_ID, MemWrite_ID,
        input  Link_ID, Slt_ID, Sgt_ID, ALUOp_ID,
        output PCPlus1_IDEX, ReadData1_IDEX, ReadData2_IDEX, Imm_IDEX,
        output Rs_IDEX, Rt_IDEX, Rd_IDEX,
        output RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
        output Link_IDEX, Slt_IDEX, Sgt_IDEX, ALUOp_IDEX,
        output lessthan_IDEX, greaterthan_IDEX, Valid_IDEX,
        output SelConflict_IDEX, BubbleCount
    );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with decode-side operand compare,
// stall/flush control and a saturating bubble counter.
module idex_stage_reg #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 3,
    parameter int SIGNED_CMP = 1,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic rst_n,
    idex_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  link;
        logic                  slt;
        logic                  sgt;
        logic [ALUOP_W-1:0]    alu_op;
        logic                  lt;
        logic                  gt;
        logic                  valid;
        logic                  sel_conflict;
    } idex_t;

    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             lt_id, gt_id, conflict_id;
    logic [1:0]       sel_sum;
    logic             bubble;

    // Operand compare on the decode-stage values
    always_comb begin
        lt_id = 1'b0;
        gt_id = 1'b0;
        if (SIGNED_CMP != 0) begin
            lt_id = $signed(bus.ReadData1_ID) < $signed(bus.ReadData2_ID);
            gt_id = $signed(bus.ReadData1_ID) > $signed(bus.ReadData2_ID);
        end else begin
            lt_id = bus.ReadData1_ID < bus.ReadData2_ID;
            gt_id = bus.ReadData1_ID > bus.ReadData2_ID;
        end
    end

    // More than one forwarded-result source selected at once
    always_comb begin
        sel_sum = {1'b0, bus.Link_ID} + {1'b0, bus.Slt_ID}
                + {1'b0, bus.Sgt_ID};
        conflict_id = bus.Valid_IFID && (sel_sum > 2'd1);
    end

    // Next state: flush beats stall beats load
    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        bubble = 1'b0;
        if (bus.Flush_IDEX) begin
            idex_d = '0;
            bubble = 1'b1;
        end else if (!bus.Stall_IDEX) begin
            idex_d.pc           = bus.PCPlus1_IFID;
            idex_d.rd1          = bus.ReadData1_ID;
            idex_d.rd2          = bus.ReadData2_ID;
            idex_d.imm          = bus.Imm_ID;
            idex_d.rs           = bus.Rs_ID;
            idex_d.rt           = bus.Rt_ID;
            idex_d.rd           = bus.Rd_ID;
            idex_d.alu_op       = bus.ALUOp_ID;
            idex_d.lt           = lt_id;
            idex_d.gt           = gt_id;
            idex_d.valid        = bus.Valid_IFID;
            idex_d.sel_conflict = conflict_id;
            idex_d.reg_write    = bus.Valid_IFID & bus.RegWrite_ID;
            idex_d.mem_read     = bus.Valid_IFID & bus.MemRead_ID;
            idex_d.mem_write    = bus.Valid_IFID & bus.MemWrite_ID;
            idex_d.link         = bus.Valid_IFID & bus.Link_ID;
            idex_d.slt          = bus.Valid_IFID & bus.Slt_ID;
            idex_d.sgt          = bus.Valid_IFID & bus.Sgt_ID;
            bubble              = !bus.Valid_IFID;
        end
        if (bubble && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.PCPlus1_IDEX     = idex_q.pc;
    assign bus.ReadData1_IDEX   = idex_q.rd1;
    assign bus.ReadData2_IDEX   = idex_q.rd2;
    assign bus.Imm_IDEX         = idex_q.imm;
    assign bus.Rs_IDEX          = idex_q.rs;
    assign bus.Rt_IDEX          = idex_q.rt;
    assign bus.Rd_IDEX          = idex_q.rd;
    assign bus.RegWrite_IDEX    = idex_q.reg_write;
    assign bus.MemRead_IDEX     = idex_q.mem_read;
    assign bus.MemWrite_IDEX    = idex_q.mem_write;
    assign bus.Link_IDEX        = idex_q.link;
    assign bus.Slt_IDEX         = idex_q.slt;
    assign bus.Sgt_IDEX         = idex_q.sgt;
    assign bus.ALUOp_IDEX       = idex_q.alu_op;
    assign bus.lessthan_IDEX    = idex_q.lt;
    assign bus.greaterthan_IDEX = idex_q.gt;
    assign bus.Valid_IDEX       = idex_q.valid;
    assign bus.SelConflict_IDEX = idex_q.sel_conflict;
    assign bus.BubbleCount      = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: a signed-compare and an
// unsigned-compare instance share the same decode-side inputs.
module tb_idex_stage_reg;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [7:0] imm;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [5:0] ctl;
        logic [2:0] aluop;
        logic       lt;
        logic       gt;
        logic       valid;
        logic       selc;
        logic [7:0] cnt;
        logic       ult;
        logic       ugt;
    } obs_t;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    obs_t  m;
    obs_t  exp_q[$];
    string tag_q[$];

    idex_if ifs ();
    idex_if ifu ();

    idex_stage_reg #(.SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );
    idex_stage_reg #(.SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(ifu)
    );

    assign ifu.Stall_IDEX   = ifs.Stall_IDEX;
    assign ifu.Flush_IDEX   = ifs.Flush_IDEX;
    assign ifu.Valid_IFID   = ifs.Valid_IFID;
    assign ifu.PCPlus1_IFID = ifs.PCPlus1_IFID;
    assign ifu.ReadData1_ID = ifs.ReadData1_ID;
    assign ifu.ReadData2_ID = ifs.ReadData2_ID;
    assign ifu.Imm_ID       = ifs.Imm_ID;
    assign ifu.Rs_ID        = ifs.Rs_ID;
    assign ifu.Rt_ID        = ifs.Rt_ID;
    assign ifu.Rd_ID        = ifs.Rd_ID;
    assign ifu.RegWrite_ID  = ifs.RegWrite_ID;
    assign ifu.MemRead_ID   = ifs.MemRead_ID;
    assign ifu.MemWrite_ID  = ifs.MemWrite_ID;
    assign ifu.Link_ID      = ifs.Link_ID;
    assign ifu.Slt_ID       = ifs.Slt_ID;
    assign ifu.Sgt_ID       = ifs.Sgt_ID;
    assign ifu.ALUOp_ID     = ifs.ALUOp_ID;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.pc    = ifs.PCPlus1_IDEX;
        o.rd1   = ifs.ReadData1_IDEX;
        o.rd2   = ifs.ReadData2_IDEX;
        o.imm   = ifs.Imm_IDEX;
        o.rs    = ifs.Rs_IDEX;
        o.rt    = ifs.Rt_IDEX;
        o.rd    = ifs.Rd_IDEX;
        o.ctl   = {ifs.RegWrite_IDEX, ifs.MemRead_IDEX,
                   ifs.MemWrite_IDEX, ifs.Link_IDEX,
                   ifs.Slt_IDEX, ifs.Sgt_IDEX};
        o.aluop = ifs.ALUOp_IDEX;
        o.lt    = ifs.lessthan_IDEX;
        o.gt    = ifs.greaterthan_IDEX;
        o.valid = ifs.Valid_IDEX;
        o.selc  = ifs.SelConflict_IDEX;
        o.cnt   = ifs.BubbleCount;
        o.ult   = ifu.lessthan_IDEX;
        o.ugt   = ifu.greaterthan_IDEX;
        return o;
    endfunction

    // Monitor: compare each registered output against the queue
    always @(posedge clk) begin
        obs_t  e;
        obs_t  g;
        string t;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", t, g, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_ins(input logic [7:0] pc, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] imm,
                           input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] rd, input logic [5:0] ctl,
                           input logic [2:0] aop, input logic v);
        ifs.PCPlus1_IFID = pc;
        ifs.ReadData1_ID = r1;
        ifs.ReadData2_ID = r2;
        ifs.Imm_ID       = imm;
        ifs.Rs_ID        = rs;
        ifs.Rt_ID        = rt;
        ifs.Rd_ID        = rd;
        {ifs.RegWrite_ID, ifs.MemRead_ID, ifs.MemWrite_ID,
         ifs.Link_ID, ifs.Slt_ID, ifs.Sgt_ID} = ctl;
        ifs.ALUOp_ID     = aop;
        ifs.Valid_IFID   = v;
    endtask

    // Drive one edge, predict its result, then return at the next negedge
    task automatic step(input logic stall, input logic flush,
                        input string tag);
        obs_t n;
        int   a, b, nsel;
        ifs.Stall_IDEX = stall;
        ifs.Flush_IDEX = flush;
        n = m;
        if (flush) begin
            n = '0;
            n.cnt = (m.cnt == 8'hFF) ? 8'hFF : m.cnt + 8'd1;
        end else if (!stall) begin
            a = int'(ifs.ReadData1_ID);
            b = int'(ifs.ReadData2_ID);
            n.ult = a < b;
            n.ugt = a > b;
            if (a >= 128) a = a - 256;
            if (b >= 128) b = b - 256;
            n.lt    = a < b;
            n.gt    = a > b;
            n.pc    = ifs.PCPlus1_IFID;
            n.rd1   = ifs.ReadData1_ID;
            n.rd2   = ifs.ReadData2_ID;
            n.imm   = ifs.Imm_ID;
            n.rs    = ifs.Rs_ID;
            n.rt    = ifs.Rt_ID;
            n.rd    = ifs.Rd_ID;
            n.aluop = ifs.ALUOp_ID;
            n.valid = ifs.Valid_IFID;
            nsel = int'(ifs.Link_ID) + int'(ifs.Slt_ID) + int'(ifs.Sgt_ID);
            if (ifs.Valid_IFID) begin
                n.ctl  = {ifs.RegWrite_ID, ifs.MemRead_ID,
                          ifs.MemWrite_ID, ifs.Link_ID,
                          ifs.Slt_ID, ifs.Sgt_ID};
                n.selc = nsel > 1;
            end else begin
                n.ctl  = '0;
                n.selc = 1'b0;
                n.cnt  = (m.cnt == 8'hFF) ? 8'hFF : m.cnt + 8'd1;
            end
        end
        m = n;
        exp_q.push_back(n);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    initial begin
        int waits;
        total = 0;
        bad   = 0;
        m     = '0;
        rst_n = 1'b0;
        ifs.Stall_IDEX = 1'b0;
        ifs.Flush_IDEX = 1'b0;
        set_ins(8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0,
                6'b0, 3'd0, 1'b0);
        #1;
        chk("reset_all", 32'(observe()), 32'd0);
        chk("reset_hi", 32'(observe() >> 32), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // FF vs 01: signed less, unsigned greater
        set_ins(8'h10, 8'hFF, 8'h01, 8'h05, 3'd1, 3'd2, 3'd3,
                6'b100010, 3'd2, 1'b1);
        step(1'b0, 1'b0, "cmp_ff_01");
        chk("s_lt_ff01", 32'(ifs.lessthan_IDEX), 32'd1);
        chk("s_gt_ff01", 32'(ifs.greaterthan_IDEX), 32'd0);
        chk("u_lt_ff01", 32'(ifu.lessthan_IDEX), 32'd0);
        chk("u_gt_ff01", 32'(ifu.greaterthan_IDEX), 32'd1);

        set_ins(8'h11, 8'h42, 8'h42, 8'h00, 3'd4, 3'd5, 3'd6,
                6'b110000, 3'd1, 1'b1);
        step(1'b0, 1'b0, "cmp_eq");
        chk("eq_flags", 32'({ifs.lessthan_IDEX, ifs.greaterthan_IDEX,
                             ifu.lessthan_IDEX, ifu.greaterthan_IDEX}),
            32'd0);

        set_ins(8'h12, 8'h80, 8'h7F, 8'hAA, 3'd7, 3'd0, 3'd1,
                6'b001000, 3'd7, 1'b1);
        step(1'b0, 1'b0, "cmp_80_7f");
        chk("s_lt_807f", 32'(ifs.lessthan_IDEX), 32'd1);
        chk("u_gt_807f", 32'(ifu.greaterthan_IDEX), 32'd1);

        // Stall holds a loaded Slt instruction
        set_ins(8'h10, 8'h03, 8'h09, 8'h01, 3'd2, 3'd3, 3'd4,
                6'b100010, 3'd3, 1'b1);
        step(1'b0, 1'b0, "stall_load");
        set_ins(8'h55, 8'h01, 8'h00, 8'hEE, 3'd5, 3'd6, 3'd7,
                6'b000101, 3'd6, 1'b0);
        step(1'b1, 1'b0, "stall_1");
        set_ins(8'h66, 8'h02, 8'h00, 8'hDD, 3'd1, 3'd1, 3'd1,
                6'b010001, 3'd5, 1'b1);
        step(1'b1, 1'b0, "stall_2");
        step(1'b1, 1'b0, "stall_3");
        chk("stall_slt", 32'(ifs.Slt_IDEX), 32'd1);
        chk("stall_pc", 32'(ifs.PCPlus1_IDEX), 32'h10);
        chk("stall_valid", 32'(ifs.Valid_IDEX), 32'd1);
        chk("stall_cnt", 32'(ifs.BubbleCount), 32'd0);

        // Flush overrides stall
        set_ins(8'h20, 8'h04, 8'h02, 8'h00, 3'd1, 3'd2, 3'd3,
                6'b100100, 3'd4, 1'b1);
        step(1'b1, 1'b1, "flush_stall");
        chk("fs_link", 32'(ifs.Link_IDEX), 32'd0);
        chk("fs_valid", 32'(ifs.Valid_IDEX), 32'd0);
        chk("fs_cnt", 32'(ifs.BubbleCount), 32'd1);

        // Link+Sgt conflict, then the same with an invalid slot
        set_ins(8'h30, 8'h05, 8'h05, 8'h00, 3'd1, 3'd2, 3'd3,
                6'b100101, 3'd0, 1'b1);
        step(1'b0, 1'b0, "conflict_v");
        chk("cf_sel", 32'(ifs.SelConflict_IDEX), 32'd1);
        chk("cf_link_sgt", 32'({ifs.Link_IDEX, ifs.Sgt_IDEX}), 32'd3);
        set_ins(8'h30, 8'h05, 8'h05, 8'h00, 3'd1, 3'd2, 3'd3,
                6'b100101, 3'd0, 1'b0);
        step(1'b0, 1'b0, "conflict_inv");
        chk("cfi_bits", 32'({ifs.Link_IDEX, ifs.Sgt_IDEX,
                             ifs.SelConflict_IDEX}), 32'd0);
        chk("cfi_cnt", 32'(ifs.BubbleCount), 32'd2);

        // Reset between edges clears everything at once
        set_ins(8'h40, 8'h09, 8'h08, 8'h07, 3'd6, 3'd5, 3'd4,
                6'b111111, 3'd7, 1'b1);
        step(1'b0, 1'b0, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_lo", 32'(observe()), 32'd0);
        chk("mid_reset_hi", 32'(observe() >> 32), 32'd0);
        m = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Bubble counter saturates and then holds
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, "sat_flush");
        end
        chk("sat_ff", 32'(ifs.BubbleCount), 32'hFF);
        step(1'b0, 1'b1, "sat_hold");
        chk("sat_hold", 32'(ifs.BubbleCount), 32'hFF);

        set_ins(8'h50, 8'h00, 8'hFF, 8'h01, 3'd3, 3'd3, 3'd3,
                6'b000001, 3'd2, 1'b1);
        step(1'b0, 1'b0, "cmp_00_ff");
        chk("s_gt_00ff", 32'(ifs.greaterthan_IDEX), 32'd1);
        chk("u_lt_00ff", 32'(ifu.lessthan_IDEX), 32'd1);

        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
ID/EX pipeline register for the 8-bit pipelined core. It captures decode-stage operands, control bits and register addresses at each clock. It also computes the operand-compare flags in the decode stage and registers them for the execute-stage forwarded-value mux, which selects among link address, set-less-than and set-greater-than results. It supports hazard-unit stall (hold) and flush (bubble insertion), and keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 8, datapath/PC width
REG_ADDR_W, 3, register-file address width
ALUOP_W, 3, ALU operation code width
SIGNED_CMP, 1, 1 = two's-complement compare, 0 = unsigned compare
CNT_W, 8, bubble counter width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall_IDEX  in  1  hold all IDEX contents this cycle
Flush_IDEX  in  1  load a bubble this cycle
Valid_IFID  in  1  decode-stage instruction valid
PCPlus1_IFID  in  DATA_W  PC+1 of decode instruction
ReadData1_ID  in  DATA_W  rs operand
ReadData2_ID  in  DATA_W  rt operand
Imm_ID  in  DATA_W  extended immediate
Rs_ID, Rt_ID, Rd_ID  in  REG_ADDR_W each  register addresses
RegWrite_ID, MemRead_ID, MemWrite_ID, Link_ID, Slt_ID, Sgt_ID  in  1 each  decoded control
ALUOp_ID  in  ALUOP_W  ALU operation
PCPlus1_IDEX, ReadData1_IDEX, ReadData2_IDEX, Imm_IDEX  out  DATA_W  registered data
Rs_IDEX, Rt_IDEX, Rd_IDEX  out  REG_ADDR_W  registered addresses
RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, Link_IDEX, Slt_IDEX, Sgt_IDEX  out  1  registered control
ALUOp_IDEX  out  ALUOP_W  registered ALU op
lessthan_IDEX, greaterthan_IDEX  out  1  registered compare of ReadData1_ID vs ReadData2_ID
Valid_IDEX  out  1  execute-stage instruction valid
SelConflict_IDEX  out  1  more than one of Link/Slt/Sgt was decoded
BubbleCount  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, including BubbleCount. Reset asserted mid-operation clears the register immediately. No partial state survives.
- Per-edge priority is Flush > Stall > Load.
- Flush=1: Valid, RegWrite, MemRead, MemWrite, Link, Slt, Sgt, lessthan, greaterthan and SelConflict go to 0, and ALUOp goes to 0. Data and address fields go to 0. BubbleCount increments by 1 and saturates at all-ones; it never wraps. Flush overrides a simultaneous Stall.
- Stall=1, Flush=0: every field holds, including Valid. BubbleCount holds.
- Load (both 0): all fields take their _ID/_IFID inputs; Valid_IDEX takes Valid_IFID.
  - If Valid_IFID=0, the control bits load as 0 (bubble from upstream). BubbleCount increments, saturating.
- Compare, evaluated combinationally on the ID inputs and captured on load:
  - lessthan = (ReadData1 < ReadData2); greaterthan = (ReadData1 > ReadData2).
  - Signed when SIGNED_CMP=1, unsigned otherwise.
  - Equal operands give both flags 0. The two flags are never both 1.
- SelConflict loads (Link+Slt+Sgt > 1) when Valid_IFID=1. The control bits are still passed unmodified; the flag is debug only.
- Latency: exactly one cycle from ID inputs to IDEX outputs. There is no combinational path from any input to any output.

Test Plan:
- Reset mid-stream: load a valid instruction, drop rst_n between edges -> all outputs 0 immediately, BubbleCount=0.
- Signed compare (SIGNED_CMP=1): ReadData1=8'hFF, ReadData2=8'h01, load -> lessthan_IDEX=1, greaterthan_IDEX=0. Same operands with SIGNED_CMP=0 -> lessthan=0, greaterthan=1. Equal 8'h42/8'h42 -> both 0.
- Stall hold: load Slt_ID=1, PCPlus1=8'h10, then Stall=1 for 3 cycles with changed inputs -> outputs stay Slt=1, PCPlus1=8'h10, Valid=1.
- Flush beats stall: Stall=1 and Flush=1 on the same edge with Link_ID=1 -> Link_IDEX=0, Valid_IDEX=0, BubbleCount increments by 1.
- Counter saturation: 260 consecutive flushes -> BubbleCount=8'hFF, then holds on a further flush.
- Conflict: Valid_IFID=1, Link_ID=1, Sgt_ID=1 -> SelConflict_IDEX=1, with Link_IDEX and Sgt_IDEX both 1. Same inputs with Valid_IFID=0 -> all three 0.
